latent_sampler: RTL and testbench

Upstream latent-vector source for the simple GAN generator. Produces one LATENT_DIM vector of Q8.8 pseudo-random samples from a 32-bit Galois LFSR, uniform or Gaussian-approximate, and presents it with a one-cycle `valid_out` pulse that drives the generator's `valid_in`. It then holds off until the generator reports `done`, so a vector is never offered while the generator is busy.

---
 rtl/simple_gan_pkg.sv | 47 ++++
 rtl/latent_sampler_if.sv | 38 +++
 rtl/latent_sampler_lfsr32_galois.sv | 38 +++
 rtl/latent_sampler.sv | 194 +++++++++++++++++++
 tb/tb_latent_sampler.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_gan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simple_gan_pkg
//  Description : Shared constants, types and helpers for the simple GAN
//                datapath: Q8.8 sample format, LFSR polynomial, default seed
//                and the latent sampler state encoding.
//                LATENT_GAUSS_EN selects four draws per latent element
//                (Irwin-Hall sum) instead of one uniform draw.
//  Revision    : 1.0  initial release
// ============================================================================
package simple_gan_pkg;

    // Q8.8 signed sample format
    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;
    localparam int INT_BITS   = DATA_WIDTH - FRAC_BITS;

    // Galois right-shift LFSR feedback mask and lock-up-safe default seed
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] SEED_DEFAULT = 32'hACE1_2345;

    // One raw draw is lfsr[8:0] read as a signed 9-bit value
    localparam int DRAW_BITS = 9;

`ifdef LATENT_GAUSS_EN
    localparam int DRAWS = 4;
`else
    localparam int DRAWS = 1;
`endif

    // Sum of DRAWS signed 9-bit draws needs log2(DRAWS) extra bits
    localparam int SUM_BITS = DRAW_BITS + $clog2(DRAWS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAW    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_WAIT    = 2'd3
    } sampler_state_e;

    // One Galois step: shift right, fold the taps in when a 1 falls out
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/latent_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module      : latent_sampler_if
//  Description : Control and vector hand-off bundle between the latent
//                sampler and its consumer (GAN generator + controller).
//                master : the sampler (drives latent_out/valid_out/busy/
//                         sample_count, receives start/run/seed/gen_done)
//                slave  : the consumer side (opposite directions)
//  Signals     : start, run, seed_load, seed_in[31:0], gen_done,
//                latent_out[0:LATENT_DIM-1], valid_out, busy,
//                sample_count[15:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface latent_sampler_if #(
    parameter int LATENT_DIM = 2,
    parameter int DATA_WIDTH = 16
);
    logic                         start;
    logic                         run;
    logic                         seed_load;
    logic [31:0]                  seed_in;
    logic                         gen_done;
    logic signed [DATA_WIDTH-1:0] latent_out [LATENT_DIM];
    logic                         valid_out;
    logic                         busy;
    logic [15:0]                  sample_count;

    modport master (
        input  start, run, seed_load, seed_in, gen_done,
        output latent_out, valid_out, busy, sample_count
    );

    modport slave (
        output start, run, seed_load, seed_in, gen_done,
        input  latent_out, valid_out, busy, sample_count
    );
endinterface
`default_nettype wire

// File: rtl/latent_sampler_lfsr32_galois.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr32_galois
//  Description : 32-bit Galois right-shift LFSR with synchronous seed load.
//                A zero seed is replaced by SEED_DEFAULT so the register can
//                never reach the all-zero lock-up state. load wins over step.
//  Ports       : clk, rst_n (async, active-low), load, seed[31:0], step,
//                value[31:0] (current register contents)
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr32_galois #(
    parameter logic [31:0] SEED_DEFAULT = simple_gan_pkg::SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] value
);
    import simple_gan_pkg::*;

    logic [31:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED_DEFAULT;
        end else if (load) begin
            r_lfsr <= (seed == 32'd0) ? SEED_DEFAULT : seed;
        end else if (step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/latent_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : latent_sampler
//  Description : Draws one LATENT_DIM vector of Q8.8 pseudo-random samples,
//                presents it with a one-cycle valid_out pulse, then waits for
//                the generator's gen_done before drawing again (run=1) or
//                returning to idle (run=0).
//                Build option LATENT_GAUSS_EN: each element is the sum of four
//                consecutive 9-bit signed draws (Gaussian approximation);
//                otherwise each element is a single uniform draw.
//  Ports       : clk, rst_n (async, active-low),
//                bus (latent_sampler_if.master): start, run, seed_load,
//                seed_in, gen_done -> latent_out[], valid_out, busy,
//                sample_count
//  Revision    : 1.0  initial release
// ============================================================================
module latent_sampler #(
    parameter int          LATENT_DIM   = 2,
    parameter int          DATA_WIDTH   = simple_gan_pkg::DATA_WIDTH,
    parameter logic [31:0] SEED_DEFAULT = simple_gan_pkg::SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    latent_sampler_if.master  bus
);
    import simple_gan_pkg::*;

    localparam int              ELEM_W      = (LATENT_DIM > 1) ? $clog2(LATENT_DIM) : 1;
    localparam logic [ELEM_W-1:0] c_last_elem = ELEM_W'(LATENT_DIM - 1);

    sampler_state_e r_state;
    sampler_state_e w_next_state;

    logic [31:0]                  w_lfsr;
    logic                         w_load;
    logic                         w_step;
    logic                         w_clear;
    logic                         w_elem_done;
    logic signed [DRAW_BITS-1:0]  w_draw;
    logic signed [SUM_BITS-1:0]   w_sum;
    logic                         w_unused_lfsr_hi;

    logic [ELEM_W-1:0]            r_elem;
    logic signed [DATA_WIDTH-1:0] r_latent [LATENT_DIM];
    logic                         r_valid;
    logic                         r_busy;
    logic [15:0]                  r_count;

    // ------------------------------------------------------------------
    // Random source
    // ------------------------------------------------------------------
    lfsr32_galois #(
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .seed  (bus.seed_in),
        .step  (w_step),
        .value (w_lfsr)
    );

    // Draw is taken from the register before it steps this cycle
    assign w_draw           = $signed(w_lfsr[DRAW_BITS-1:0]);
    assign w_unused_lfsr_hi = ^w_lfsr[31:DRAW_BITS];

    // ------------------------------------------------------------------
    // Per-element accumulation
    // ------------------------------------------------------------------
`ifdef LATENT_GAUSS_EN
    localparam int DCNT_W = $clog2(DRAWS);

    logic [DCNT_W-1:0]          r_draw_cnt;
    logic signed [SUM_BITS-1:0] r_acc;

    assign w_elem_done = (r_draw_cnt == DCNT_W'(DRAWS - 1));
    // Signed size cast sign-extends the draw before it joins the sum
    assign w_sum       = r_acc + SUM_BITS'(w_draw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_draw_cnt <= '0;
            r_acc      <= '0;
        end else if (w_clear) begin
            r_draw_cnt <= '0;
            r_acc      <= '0;
        end else if (r_state == ST_DRAW) begin
            if (w_elem_done) begin
                r_draw_cnt <= '0;
                r_acc      <= '0;
            end else begin
                r_draw_cnt <= r_draw_cnt + DCNT_W'(1);
                r_acc      <= w_sum;
            end
        end
    end
`else
    assign w_elem_done = 1'b1;
    assign w_sum       = w_draw;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A seed load consumes the cycle even if start is also high
                if (bus.seed_load) begin
                    w_load = 1'b1;
                end else if (bus.start || bus.run) begin
                    w_next_state = ST_DRAW;
                    w_clear      = 1'b1;
                end
            end
            ST_DRAW: begin
                w_step = 1'b1;
                if (w_elem_done && (r_elem == c_last_elem)) begin
                    w_next_state = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.gen_done) begin
                    w_next_state = bus.run ? ST_DRAW : ST_IDLE;
                    w_clear      = bus.run;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Element index and sample registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_elem <= '0;
            for (int i = 0; i < LATENT_DIM; i++) begin
                r_latent[i] <= '0;
            end
        end else if (w_clear) begin
            r_elem <= '0;
        end else if ((r_state == ST_DRAW) && w_elem_done) begin
            r_latent[r_elem] <= DATA_WIDTH'(w_sum);
            r_elem           <= r_elem + ELEM_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Status outputs, registered from the next state so that they line up
    // with the state itself: valid_out is high exactly in ST_PRESENT and
    // busy is high in every state but ST_IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else begin
            r_valid <= (w_next_state == ST_PRESENT);
            r_busy  <= (w_next_state != ST_IDLE);
            if (w_next_state == ST_PRESENT) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign bus.latent_out   = r_latent;
    assign bus.valid_out    = r_valid;
    assign bus.busy         = r_busy;
    assign bus.sample_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_latent_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_latent_sampler
//  Description : Self-checking bench for latent_sampler. An independent LFSR
//                model produces expected vectors that are queued when a draw
//                is requested and compared when valid_out pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_latent_sampler;

`ifdef LATENT_GAUSS_EN
    localparam int DRAWS = 4;
`else
    localparam int DRAWS = 1;
`endif
    localparam int D = 2 * DRAWS;   // cycles spent drawing a 2-element vector

    typedef struct packed {
        logic [15:0] l1;
        logic [15:0] l0;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;

    latent_sampler_if #(.LATENT_DIM(2), .DATA_WIDTH(16)) bus ();

    latent_sampler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    exp_t        last;
    logic [31:0] m_lfsr;
    logic [15:0] m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_load(input logic [31:0] s);
        m_lfsr = (s == 32'd0) ? 32'hACE1_2345 : s;
    endtask

    // Model of one vector: DRAWS signed 9-bit draws summed per element
    task automatic push_vector();
        exp_t e;
        int   sum;
        int   r;
        e = '0;
        for (int el = 0; el < 2; el++) begin
            sum = 0;
            for (int d = 0; d < DRAWS; d++) begin
                r   = int'(m_lfsr[8:0]);
                sum = sum + ((r >= 256) ? (r - 512) : r);
                if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 32'h8020_0003;
                else           m_lfsr = m_lfsr >> 1;
            end
            if (el == 0) e.l0 = 16'(sum);
            else         e.l1 = 16'(sum);
        end
        m_count = m_count + 16'd1;
        e.cnt   = m_count;
        q.push_back(e);
    endtask

    // Called right after start or gen_done is driven at a negedge. The
    // vector must appear D+1 cycles later, i.e. at the (D+1)th negedge.
    task automatic expect_vector(input string tag);
        int  lat;
        bit  seen;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start    = 1'b0;
                bus.gen_done = 1'b0;
            end
            lat = k;
            if (bus.valid_out === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, lat, D + 1);
        if (seen) begin
            check({tag, "_qsize"}, q.size(), 1);
            if (q.size() > 0) begin
                last = q.pop_front();
                check({tag, "_l0"},  $unsigned(bus.latent_out[0]), last.l0);
                check({tag, "_l1"},  $unsigned(bus.latent_out[1]), last.l1);
                check({tag, "_cnt"}, bus.sample_count, last.cnt);
            end
        end
        @(negedge clk);
        check({tag, "_pulse"}, bus.valid_out, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_valid;
        logic busy_low;

        bus.start     = 1'b0;
        bus.run       = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in   = 32'd0;
        bus.gen_done  = 1'b0;
        rst_n         = 1'b0;
        m_lfsr        = 32'hACE1_2345;
        m_count       = 16'd0;
        last          = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", bus.valid_out, 1'b0);
        check("rst_busy",  bus.busy, 1'b0);
        check("rst_cnt",   bus.sample_count, 16'd0);
        check("rst_l0",    $unsigned(bus.latent_out[0]), 16'd0);
        check("rst_l1",    $unsigned(bus.latent_out[1]), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Seed 1, first vector
        bus.seed_load = 1'b1;
        bus.seed_in   = 32'h0000_0001;
        m_load(32'h0000_0001);
        @(negedge clk);
        bus.seed_load = 1'b0;
        check("seed_idle_busy", bus.busy, 1'b0);
        bus.start = 1'b1;
        push_vector();
        expect_vector("v1");
`ifdef LATENT_GAUSS_EN
        check("v1_gauss_l0", $unsigned(bus.latent_out[0]), 16'h0007);
`else
        check("v1_uni_l0", $unsigned(bus.latent_out[0]), 16'h0001);
        check("v1_uni_l1", $unsigned(bus.latent_out[1]), 16'h0003);
`endif
        check("v1_wait_busy", bus.busy, 1'b1);

        // start and seed_load in ST_WAIT are ignored
        bus.start     = 1'b1;
        bus.seed_load = 1'b1;
        bus.seed_in   = 32'h1234_5678;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_ign_valid", bus.valid_out, 1'b0);
        check("wait_ign_busy",  bus.busy, 1'b1);
        check("wait_hold_l0",   $unsigned(bus.latent_out[0]), last.l0);

        // gen_done with run=0 returns to idle
        bus.gen_done = 1'b1;
        @(negedge clk);
        bus.gen_done = 1'b0;
        check("done_idle_busy", bus.busy, 1'b0);

        // Next vector continues the untouched LFSR sequence
        bus.start = 1'b1;
        push_vector();
        expect_vector("v2");
        bus.gen_done = 1'b1;
        @(negedge clk);
        bus.gen_done = 1'b0;

        // start + seed_load together in idle: zero seed loaded, no draw
        bus.start     = 1'b1;
        bus.seed_load = 1'b1;
        bus.seed_in   = 32'h0000_0000;
        m_load(32'h0000_0000);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        any_valid = 1'b0;
        busy_low  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.valid_out !== 1'b0) any_valid = 1'b1;
            if (bus.busy !== 1'b0)      busy_low  = 1'b0;
        end
        check("both_no_valid", any_valid, 1'b0);
        check("both_no_draw",  busy_low, 1'b1);
        bus.start = 1'b1;
        push_vector();
        expect_vector("v3");
`ifndef LATENT_GAUSS_EN
        check("v3_zero_seed_l0", $unsigned(bus.latent_out[0]), 16'hFF45);
`endif

        // Free-run: generator holds done off for 20 cycles
        bus.run   = 1'b1;
        any_valid = 1'b0;
        busy_low  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.valid_out !== 1'b0) any_valid = 1'b1;
            if (bus.busy !== 1'b1)      busy_low  = 1'b1;
        end
        check("fr_no_early_valid", any_valid, 1'b0);
        check("fr_busy_hold",      busy_low, 1'b0);
        bus.gen_done = 1'b1;
        push_vector();
        expect_vector("fr1");
        check("fr1_busy", bus.busy, 1'b1);
        repeat (5) @(negedge clk);
        bus.gen_done = 1'b1;
        push_vector();
        expect_vector("fr2");
        check("fr2_busy", bus.busy, 1'b1);

        // Leave free-run
        bus.run      = 1'b0;
        bus.gen_done = 1'b1;
        @(negedge clk);
        bus.gen_done = 1'b0;
        check("fr_stop_busy", bus.busy, 1'b0);

        // Asynchronous reset in the middle of a draw
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("mid_draw_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", bus.valid_out, 1'b0);
        check("arst_busy",  bus.busy, 1'b0);
        check("arst_cnt",   bus.sample_count, 16'd0);
        check("arst_l0",    $unsigned(bus.latent_out[0]), 16'd0);
        check("arst_l1",    $unsigned(bus.latent_out[1]), 16'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_lfsr  = 32'hACE1_2345;
        m_count = 16'd0;
        @(negedge clk);
        bus.start = 1'b1;
        push_vector();
        expect_vector("post_rst");
`ifndef LATENT_GAUSS_EN
        check("post_rst_l0", $unsigned(bus.latent_out[0]), 16'hFF45);
`endif
        check("post_rst_cnt", bus.sample_count, 16'd1);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
